min_cost_select: RTL

- Parametrised best-match selector for the block-matching pipeline. Sits after the cost (XOR/popcount) stage and before the disparity output stage.
- Per reference block, consumes a stream of candidate costs and tracks the best and second-best cost. Emits one result per block, with a uniqueness check and a max-cost check; rejected results are marked invalid.
- Generalises the earlier single-minimum finder in four ways:
  - configurable cost and payload widths;
  - explicit end-of-search marker instead of fixed last coordinates;
  - second-best tracking and uniqueness rejection;
  - valid/ready backpressure on the output.

---
 rtl/min_cost_select.sv | 154 +++++++++++++++
 1 files changed

// File: rtl/min_cost_select.sv
// Best-match selector for the block-matching pipeline.
// Tracks the lowest and second-lowest candidate cost of each reference block,
// then emits one result per block with uniqueness and max-cost rejection.
// The output is a single register with valid/ready handshake.
module min_cost_select #(
  parameter int COST_W      = 9,
  parameter int PAYLOAD_W   = 256,
  parameter int COORD_W     = 16,
  parameter int IDX_W       = 16,
  parameter int UNIQ_THRESH = 4,
  parameter int MAX_COST    = 2**COST_W - 1
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 i_cand_valid,
  output logic                 o_cand_ready,
  input  logic [COST_W-1:0]    i_cand_cost,
  input  logic [PAYLOAD_W-1:0] i_cand_payload,
  input  logic [COORD_W-1:0]   i_cand_coords,
  input  logic [IDX_W-1:0]     i_cand_blk_idx,
  input  logic                 i_cand_last,
  output logic                 o_out_valid,
  input  logic                 i_out_ready,
  output logic [COST_W-1:0]    o_out_cost,
  output logic [COST_W-1:0]    o_out_cost2,
  output logic [PAYLOAD_W-1:0] o_out_payload,
  output logic [COORD_W-1:0]   o_out_coords,
  output logic [IDX_W-1:0]     o_out_blk_idx,
  output logic                 o_out_reject
);

  // Extra headroom so (second - best) * 16 and best * threshold never overflow.
  localparam int EXT_W = COST_W + 5;
  localparam logic [EXT_W-1:0] MAX_COST_EXT = EXT_W'(MAX_COST);
  localparam logic [EXT_W-1:0] UNIQ_EXT     = EXT_W'(UNIQ_THRESH);

  logic                 r_first;
  logic [COST_W-1:0]    r_best;
  logic [COST_W-1:0]    r_second;
  logic [PAYLOAD_W-1:0] r_bestPayload;
  logic [COORD_W-1:0]   r_bestCoords;
  logic [IDX_W-1:0]     r_bestBlkIdx;

  logic                 r_outValid;
  logic [COST_W-1:0]    r_outCost;
  logic [COST_W-1:0]    r_outCost2;
  logic [PAYLOAD_W-1:0] r_outPayload;
  logic [COORD_W-1:0]   r_outCoords;
  logic [IDX_W-1:0]     r_outBlkIdx;
  logic                 r_outReject;

  logic                 w_accept;
  logic                 w_takeBest;
  logic [COST_W-1:0]    w_nextBest;
  logic [COST_W-1:0]    w_nextSecond;
  logic [PAYLOAD_W-1:0] w_nextPayload;
  logic [COORD_W-1:0]   w_nextCoords;
  logic [IDX_W-1:0]     w_nextBlkIdx;
  logic [EXT_W-1:0]     w_bestExt;
  logic [EXT_W-1:0]     w_secondExt;
  logic [EXT_W-1:0]     w_gap;
  logic                 w_reject;

  // A held result stalls every candidate, so only one output register is needed.
  assign o_cand_ready = !r_outValid || i_out_ready;
  assign w_accept     = i_cand_valid && o_cand_ready;

  // Fold the incoming candidate into best/second; ties keep the earlier one.
  always_comb begin
    w_nextBest   = r_best;
    w_nextSecond = r_second;
    w_takeBest   = 1'b0;
    if (r_first) begin
      w_nextBest   = i_cand_cost;
      w_nextSecond = '1;
      w_takeBest   = 1'b1;
    end else if (i_cand_cost < r_best) begin
      w_nextBest   = i_cand_cost;
      w_nextSecond = r_best;
      w_takeBest   = 1'b1;
    end else if (i_cand_cost < r_second) begin
      w_nextSecond = i_cand_cost;
    end
    w_nextPayload = w_takeBest ? i_cand_payload : r_bestPayload;
    w_nextCoords  = w_takeBest ? i_cand_coords  : r_bestCoords;
    w_nextBlkIdx  = w_takeBest ? i_cand_blk_idx : r_bestBlkIdx;
  end

  // Uniqueness and max-cost rejection on the block's final best/second pair.
  always_comb begin
    w_bestExt   = EXT_W'(w_nextBest);
    w_secondExt = EXT_W'(w_nextSecond);
    w_gap       = w_secondExt - w_bestExt;
    w_reject    = (w_bestExt > MAX_COST_EXT) ||
                  ((UNIQ_THRESH != 0) && ((w_gap << 4) < (w_bestExt * UNIQ_EXT)));
  end

  // Per-block search state; a last candidate re-arms for the next block.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_first       <= 1'b1;
      r_best        <= '1;
      r_second      <= '1;
      r_bestPayload <= '0;
      r_bestCoords  <= '0;
      r_bestBlkIdx  <= '0;
    end else if (w_accept) begin
      if (i_cand_last) begin
        r_first  <= 1'b1;
        r_best   <= '1;
        r_second <= '1;
      end else begin
        r_first       <= 1'b0;
        r_best        <= w_nextBest;
        r_second      <= w_nextSecond;
        r_bestPayload <= w_nextPayload;
        r_bestCoords  <= w_nextCoords;
        r_bestBlkIdx  <= w_nextBlkIdx;
      end
    end
  end

  // Output register: load on a last candidate, otherwise clear once consumed.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_outValid   <= 1'b0;
      r_outCost    <= '1;
      r_outCost2   <= '1;
      r_outPayload <= '0;
      r_outCoords  <= '1;
      r_outBlkIdx  <= '0;
      r_outReject  <= 1'b0;
    end else if (w_accept && i_cand_last) begin
      r_outValid   <= 1'b1;
      r_outCost    <= w_nextBest;
      r_outCost2   <= w_nextSecond;
      r_outPayload <= w_nextPayload;
      r_outCoords  <= w_reject ? '1 : w_nextCoords;
      r_outBlkIdx  <= w_nextBlkIdx;
      r_outReject  <= w_reject;
    end else if (r_outValid && i_out_ready) begin
      r_outValid <= 1'b0;
    end
  end

  assign o_out_valid   = r_outValid;
  assign o_out_cost    = r_outCost;
  assign o_out_cost2   = r_outCost2;
  assign o_out_payload = r_outPayload;
  assign o_out_coords  = r_outCoords;
  assign o_out_blk_idx = r_outBlkIdx;
  assign o_out_reject  = r_outReject;

endmodule
